ac97_sample_capture: RTL and testbench

//  Front end for the audio processing path. Brings the AC'97 'ready' frame strobe into
//  the system clock domain and captures left_in/right_in once per frame. Applies
//  per-frame gain with saturation and mute, and hands clean 20-bit PCM plus a one-cycle

---
 rtl/ac97_sample_capture_pkg.sv | 33 +++
 rtl/ac97_sample_capture_sat_scale.sv | 47 ++++
 rtl/ac97_sample_capture.sv | 144 ++++++++++++++
 tb/tb_ac97_sample_capture.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ac97_sample_capture_pkg.sv
// Shared widths, FSM encoding and the 20-bit saturation helper for the AC'97 capture path.
package ac97_sample_capture_pkg;

    localparam int PCM_W  = 20;
    localparam int GAIN_W = 8;
    localparam int PROD_W = 28;

    localparam logic [PCM_W-1:0] PCM_MAX = 20'h7FFFF;
    localparam logic [PCM_W-1:0] PCM_MIN = 20'h80000;

    // Limits on the unshifted product equivalent to limits on prod[27:4].
    localparam logic signed [PROD_W-1:0] PROD_HI = 28'sh07FFFFF;
    localparam logic signed [PROD_W-1:0] PROD_LO = 28'shF800000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    function automatic logic [PCM_W-1:0] sat_pcm(input logic signed [PROD_W-1:0] p);
        logic [PCM_W-1:0] r;
        if (p > PROD_HI) begin
            r = PCM_MAX;
        end else if (p < PROD_LO) begin
            r = PCM_MIN;
        end else begin
            r = p[PCM_W+3:4];
        end
        return r;
    endfunction

endpackage

// File: rtl/ac97_sample_capture_sat_scale.sv
// One PCM channel: registered Q4.4 gain product, then registered shift/saturate output.
module ac97_sample_capture_sat_scale
    import ac97_sample_capture_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [PCM_W-1:0]  sample_i,
    input  logic [GAIN_W-1:0] gain_i,
    input  logic              mute_i,
    input  logic              load_i,
    input  logic              clear_i,
    output logic [PCM_W-1:0]  sample_o
);

    logic signed [PROD_W-1:0] sample_ext;
    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] prod_d;
    logic signed [PROD_W-1:0] prod_q;
    logic [PCM_W-1:0]         out_d;
    logic [PCM_W-1:0]         out_q;

    always_comb begin
        sample_ext = {{(PROD_W-PCM_W){sample_i[PCM_W-1]}}, sample_i};
        gain_ext   = {{(PROD_W-GAIN_W){1'b0}}, gain_i};
        prod_d     = mute_i ? '0 : sample_ext * gain_ext;

        out_d = out_q;
        if (clear_i) begin
            out_d = '0;
        end else if (load_i) begin
            out_d = sat_pcm(prod_q);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prod_q <= '0;
            out_q  <= '0;
        end else begin
            prod_q <= prod_d;
            out_q  <= out_d;
        end
    end

    assign sample_o = out_q;

endmodule

// File: rtl/ac97_sample_capture.sv
// AC'97 frame capture: ready synchronizer, capture/gain pipeline and link watchdog.
// state    | meaning
// ST_IDLE  | after reset, waiting for the first frame edge
// ST_RUN   | frames arriving, watchdog and glitch counter active
// ST_STALL | no frame edge for TIMEOUT cycles, outputs zeroed
module ac97_sample_capture
    import ac97_sample_capture_pkg::*;
#(
    parameter int TIMEOUT  = 2048,
    parameter int MIN_GAP  = 256,
    parameter int WD_WIDTH = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ready,
    input  logic [PCM_W-1:0]  left_in,
    input  logic [PCM_W-1:0]  right_in,
    input  logic [GAIN_W-1:0] gain,
    input  logic              mute,
    output logic [PCM_W-1:0]  left_out,
    output logic [PCM_W-1:0]  right_out,
    output logic              sample_valid,
    output logic              link_ok,
    output logic [7:0]        glitch_count
);

    localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT - 1);
    localparam logic [WD_WIDTH-1:0] GAP_MIN = WD_WIDTH'(MIN_GAP);

    logic s1_q, s2_q, s3_q;
    logic rise;

    logic [PCM_W-1:0]  left_c_q, right_c_q;
    logic [GAIN_W-1:0] gain_c_q;
    logic              mute_c_q;
    logic              valid_c_q, valid_m_q, sample_valid_q;

    state_t               state_q;
    logic [WD_WIDTH-1:0]  wd_q;
    logic [7:0]           glitch_q;
    logic                 link_ok_q;
    logic                 stall_entry;

    assign rise        = s2_q & ~s3_q;
    assign stall_entry = (state_q == ST_RUN) & ~rise & (wd_q == WD_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= ready;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Inputs are stable while ready is high, so capturing them on the synced edge is safe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            left_c_q       <= '0;
            right_c_q      <= '0;
            gain_c_q       <= '0;
            mute_c_q       <= 1'b0;
            valid_c_q      <= 1'b0;
            valid_m_q      <= 1'b0;
            sample_valid_q <= 1'b0;
        end else begin
            if (rise) begin
                left_c_q  <= left_in;
                right_c_q <= right_in;
                gain_c_q  <= gain;
                mute_c_q  <= mute;
            end
            valid_c_q      <= rise;
            valid_m_q      <= valid_c_q;
            sample_valid_q <= valid_m_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wd_q      <= '0;
            glitch_q  <= '0;
            link_ok_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_STALL: begin
                    if (rise) begin
                        state_q   <= ST_RUN;
                        link_ok_q <= 1'b1;
                        wd_q      <= '0;
                    end
                end
                ST_RUN: begin
                    if (rise) begin
                        wd_q <= '0;
                        if (wd_q < GAP_MIN && glitch_q != 8'hFF) begin
                            glitch_q <= glitch_q + 8'd1;
                        end
                    end else if (wd_q == WD_LAST) begin
                        state_q   <= ST_STALL;
                        link_ok_q <= 1'b0;
                    end else begin
                        wd_q <= wd_q + WD_WIDTH'(1);
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    link_ok_q <= 1'b0;
                end
            endcase
        end
    end

    ac97_sample_capture_sat_scale u_left (
        .clock    (clock),
        .reset    (reset),
        .sample_i (left_c_q),
        .gain_i   (gain_c_q),
        .mute_i   (mute_c_q),
        .load_i   (valid_m_q),
        .clear_i  (stall_entry),
        .sample_o (left_out)
    );

    ac97_sample_capture_sat_scale u_right (
        .clock    (clock),
        .reset    (reset),
        .sample_i (right_c_q),
        .gain_i   (gain_c_q),
        .mute_i   (mute_c_q),
        .load_i   (valid_m_q),
        .clear_i  (stall_entry),
        .sample_o (right_out)
    );

    assign sample_valid = sample_valid_q;
    assign link_ok      = link_ok_q;
    assign glitch_count = glitch_q;

endmodule

// File: tb/tb_ac97_sample_capture.sv
// Directed bench for ac97_sample_capture with hand-computed expected samples.
module tb_ac97_sample_capture;

    logic        clock = 1'b0;
    logic        reset;
    logic        ready;
    logic [19:0] left_in, right_in;
    logic [7:0]  gain;
    logic        mute;
    logic [19:0] left_out, right_out;
    logic        sample_valid, link_ok;
    logic [7:0]  glitch_count;

    int n_checks = 0;
    int n_fail   = 0;

    ac97_sample_capture dut (
        .clock        (clock),
        .reset        (reset),
        .ready        (ready),
        .left_in      (left_in),
        .right_in     (right_in),
        .gain         (gain),
        .mute         (mute),
        .left_out     (left_out),
        .right_out    (right_out),
        .sample_valid (sample_valid),
        .link_ok      (link_ok),
        .glitch_count (glitch_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts at a falling edge; returns cycles from ready rising to sample_valid (-1 if none).
    task automatic frame(input logic [19:0] l, input logic [19:0] r, input logic [7:0] g,
                         input logic m, output int lat, output logic valid_after,
                         output int link_low);
        left_in  = l;
        right_in = r;
        gain     = g;
        mute     = m;
        ready    = 1'b1;
        lat      = -1;
        link_low = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            if (i == 4) ready = 1'b0;
            if (!link_ok) link_low++;
            if (sample_valid) begin
                lat = i;
                break;
            end
        end
        ready = 1'b0;
        @(negedge clock);
        valid_after = sample_valid;
    endtask

    task automatic idle(input int n, output int link_low, output int valids);
        link_low = 0;
        valids   = 0;
        repeat (n) begin
            @(negedge clock);
            if (!link_ok) link_low++;
            if (sample_valid) valids++;
        end
    endtask

    initial begin
        int   lat, ll, ll2, v;
        logic va;

        reset    = 1'b1;
        ready    = 1'b0;
        left_in  = '0;
        right_in = '0;
        gain     = '0;
        mute     = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_left", left_out, 20'h0);
        chk("rst_right", right_out, 20'h0);
        chk("rst_valid", sample_valid, 1'b0);
        chk("rst_link", link_ok, 1'b0);
        chk("rst_glitch", glitch_count, 8'h0);

        reset = 1'b0;
        idle(10, ll, v);
        chk("idle_link_low", ll, 10);

        frame(20'h01234, 20'hFEDCC, 8'h10, 1'b0, lat, va, ll);
        chk("unity_latency", lat, 5);
        chk("unity_one_cycle", va, 1'b0);
        chk("unity_left", left_out, 20'h01234);
        chk("unity_right", right_out, 20'hFEDCC);
        chk("unity_link", link_ok, 1'b1);
        chk("unity_glitch", glitch_count, 8'h0);
        idle(556, ll, v);
        chk("gap_no_valid", v, 0);
        chk("gap_link_low", ll, 0);

        frame(20'h40000, 20'hC0000, 8'h40, 1'b0, lat, va, ll);
        chk("sat_latency", lat, 5);
        chk("sat_left", left_out, 20'h7FFFF);
        chk("sat_right", right_out, 20'h80000);
        idle(556, ll, v);

        frame(20'h12345, 20'h54321, 8'h00, 1'b0, lat, va, ll);
        chk("gain0_left", left_out, 20'h0);
        chk("gain0_right", right_out, 20'h0);
        idle(556, ll, v);

        frame(20'h00100, 20'hFFF00, 8'h18, 1'b0, lat, va, ll);
        chk("g1p5_left", left_out, 20'h00180);
        chk("g1p5_right", right_out, 20'hFFE80);
        idle(556, ll, v);

        frame(20'h00100, 20'h00100, 8'h10, 1'b1, lat, va, ll);
        chk("mute1_latency", lat, 5);
        chk("mute1_left", left_out, 20'h0);
        chk("mute1_right", right_out, 20'h0);
        idle(556, ll, v);
        frame(20'h00100, 20'h00100, 8'h10, 1'b1, lat, va, ll);
        chk("mute2_latency", lat, 5);
        chk("mute2_left", left_out, 20'h0);
        idle(556, ll, v);

        frame(20'h0ABCD, 20'hF5433, 8'h10, 1'b0, lat, va, ll);
        chk("pre_stall_left", left_out, 20'h0ABCD);
        chk("pre_stall_right", right_out, 20'hF5433);
        idle(300, ll, v);
        chk("hold_left", left_out, 20'h0ABCD);
        chk("hold_right", right_out, 20'hF5433);

        // No frames for well over the timeout.
        idle(2000, ll, v);
        chk("stall_link", link_ok, 1'b0);
        chk("stall_left", left_out, 20'h0);
        chk("stall_right", right_out, 20'h0);
        chk("stall_no_valid", v, 0);
        chk("stall_glitch", glitch_count, 8'h0);

        frame(20'h00321, 20'hFFCDF, 8'h10, 1'b0, lat, va, ll);
        chk("resume_latency", lat, 5);
        chk("resume_left", left_out, 20'h00321);
        chk("resume_right", right_out, 20'hFFCDF);
        chk("resume_link", link_ok, 1'b1);
        chk("resume_glitch", glitch_count, 8'h0);

        // Edge spacing of exactly TIMEOUT: rise coincides with timeout and wins.
        idle(2042, ll, v);
        frame(20'h00011, 20'h00022, 8'h10, 1'b0, lat, va, ll2);
        chk("edge_2048_link_low", ll + ll2, 0);
        chk("edge_2048_left", left_out, 20'h00011);

        // Spacing of 2051 times out for a few cycles before the frame recovers the link.
        idle(2045, ll, v);
        frame(20'h00033, 20'h00044, 8'h10, 1'b0, lat, va, ll2);
        chk("edge_2051_dropped", (ll + ll2) > 0, 1'b1);
        chk("edge_2051_latency", lat, 5);
        chk("edge_2051_left", left_out, 20'h00033);
        chk("edge_2051_link", link_ok, 1'b1);
        chk("edge_2051_glitch", glitch_count, 8'h0);

        idle(251, ll, v);
        frame(20'h00055, 20'h00066, 8'h10, 1'b0, lat, va, ll);
        chk("gap_257_glitch", glitch_count, 8'h0);
        idle(250, ll, v);
        frame(20'h00077, 20'h00088, 8'h10, 1'b0, lat, va, ll);
        chk("gap_256_glitch", glitch_count, 8'h1);
        chk("gap_256_left", left_out, 20'h00077);
        chk("gap_256_latency", lat, 5);

        for (int k = 0; k < 200; k++) begin
            idle(94, ll, v);
            frame(20'h00099, 20'h000AA, 8'h10, 1'b0, lat, va, ll);
        end
        chk("glitch_201", glitch_count, 8'd201);
        chk("glitch_frame_left", left_out, 20'h00099);
        for (int k = 0; k < 100; k++) begin
            idle(94, ll, v);
            frame(20'h00099, 20'h000AA, 8'h10, 1'b0, lat, va, ll);
        end
        chk("glitch_saturated", glitch_count, 8'hFF);
        chk("glitch_link", link_ok, 1'b1);

        // Reset lands one cycle after ready rises; that frame must be discarded.
        idle(600, ll, v);
        left_in  = 20'h01111;
        right_in = 20'h02222;
        gain     = 8'h10;
        mute     = 1'b0;
        ready    = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        idle(20, ll, v);
        chk("midrst_no_valid", v, 0);
        chk("midrst_left", left_out, 20'h0);
        chk("midrst_right", right_out, 20'h0);
        chk("midrst_link_low", ll, 20);
        chk("midrst_glitch", glitch_count, 8'h0);

        frame(20'h01234, 20'h00000, 8'h10, 1'b0, lat, va, ll);
        chk("post_rst_latency", lat, 5);
        chk("post_rst_left", left_out, 20'h01234);
        chk("post_rst_link", link_ok, 1'b1);
        chk("post_rst_glitch", glitch_count, 8'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
